inverse_shift_row_byte_sub: RTL and testbench



---
 rtl/inverse_shift_row_byte_sub.sv | 213 +++++++++++++++++++++
 tb/tb_inverse_shift_row_byte_sub.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inverse_shift_row_byte_sub.sv
// ---------------------------------------------------------------------------
// inverse_shift_row_byte_sub
//
// AES decrypt-round stage: InvShiftRows followed by InvSubBytes, applied in
// place to the 16-byte state held in the shared statemt memory. Byte (row r,
// col c) lives in statemt[r + 4*c][7:0]. The result is
//   out[r + 4c] = invsbox[in[r + 4*((c - r) & 3)][7:0]]
// and each result word is written back as {24'b0, byte}.
//
// Ports
//   ap_clk, ap_rst          clock, synchronous active-high reset
//   ap_start/ap_done/
//   ap_idle/ap_ready        block-level control (see handshake note below)
//   statemt_*0 / *1         two-port state memory: address, ce, we, write
//                           data and read data (read data valid one cycle
//                           after an enabled read)
//   invsbox_*0 / *1         two read ports of the external 256x8 inverse
//                           S-box ROM (data valid one cycle after enable)
//
// Handshake: ap_start is only looked at while ap_idle is high; the cycle in
// which ap_idle=1 and ap_start=1 accepts a run. Exactly 19 cycles later
// ap_done and ap_ready pulse together for one cycle, and the block returns to
// idle the cycle after that. ap_start is ignored while a run is in flight.
//
// Sequence: RD (8 cycles, reads pairs 0/1 .. 14/15), RDW (capture of the last
// pair), LK (8 cycles of ROM look-ups; from the second LK cycle on, the
// previous pair's ROM data is written back), WR (last pair written), DONE.
// All 16 input bytes are buffered locally before any write, so overwriting
// statemt in place cannot corrupt a byte that is still needed.
// ---------------------------------------------------------------------------
module inverse_shift_row_byte_sub (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    output logic [4:0]  statemt_address0,
    output logic        statemt_ce0,
    output logic        statemt_we0,
    output logic [31:0] statemt_d0,
    input  logic [31:0] statemt_q0,
    output logic [4:0]  statemt_address1,
    output logic        statemt_ce1,
    output logic        statemt_we1,
    output logic [31:0] statemt_d1,
    input  logic [31:0] statemt_q1,
    output logic [7:0]  invsbox_address0,
    output logic        invsbox_ce0,
    input  logic [7:0]  invsbox_q0,
    output logic [7:0]  invsbox_address1,
    output logic        invsbox_ce1,
    input  logic [7:0]  invsbox_q1
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_RDW  = 3'd2,
        S_LK   = 3'd3,
        S_WR   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      state;
    logic [2:0]  cnt;       // pair index k (RD) or m (LK)
    logic [2:0]  cnt_inc;
    logic [7:0]  byte_buf [16];

    logic        cap_en;
    logic [2:0]  cap_pair;

    // Only the low byte of each state word carries data.
    logic        unused_upper;
    assign unused_upper = ^{statemt_q0[31:8], statemt_q1[31:8]};

    // Input byte index feeding output byte i: same row, column shifted
    // back by the row number (mod 4).
    function automatic logic [3:0] src_idx(input logic [3:0] i);
        logic [1:0] r;
        logic [1:0] c;
        logic [1:0] cs;
        r  = i[1:0];
        c  = i[3:2];
        cs = c - r;
        return {cs, r};
    endfunction

    assign cnt_inc = cnt + 3'd1;

    // Write data comes straight from the ROM read issued the cycle before,
    // so it is a pass-through, forced to zero whenever no write is issued.
    assign statemt_d0 = statemt_we0 ? {24'b0, invsbox_q0} : 32'b0;
    assign statemt_d1 = statemt_we1 ? {24'b0, invsbox_q1} : 32'b0;

    // Read data for pair k arrives during RD k+1 (or RDW for k=7).
    always_comb begin
        cap_en   = 1'b0;
        cap_pair = 3'd0;
        if (state == S_RD && cnt != 3'd0) begin
            cap_en   = 1'b1;
            cap_pair = cnt - 3'd1;
        end else if (state == S_RDW) begin
            cap_en   = 1'b1;
            cap_pair = 3'd7;
        end
    end

    // Buffer is intentionally never cleared by reset.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst && cap_en) begin
            byte_buf[{cap_pair, 1'b0}] <= statemt_q0[7:0];
            byte_buf[{cap_pair, 1'b1}] <= statemt_q1[7:0];
        end
    end

    // Control FSM. All memory-side outputs are registered: each state sets
    // up the enables/addresses that must be visible in the next cycle.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state            <= S_IDLE;
            cnt              <= 3'd0;
            ap_idle          <= 1'b1;
            ap_done          <= 1'b0;
            ap_ready         <= 1'b0;
            statemt_ce0      <= 1'b0;
            statemt_ce1      <= 1'b0;
            statemt_we0      <= 1'b0;
            statemt_we1      <= 1'b0;
            statemt_address0 <= 5'd0;
            statemt_address1 <= 5'd0;
            invsbox_ce0      <= 1'b0;
            invsbox_ce1      <= 1'b0;
            invsbox_address0 <= 8'd0;
            invsbox_address1 <= 8'd0;
        end else begin
            ap_done     <= 1'b0;
            ap_ready    <= 1'b0;
            statemt_ce0 <= 1'b0;
            statemt_ce1 <= 1'b0;
            statemt_we0 <= 1'b0;
            statemt_we1 <= 1'b0;
            invsbox_ce0 <= 1'b0;
            invsbox_ce1 <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        state            <= S_RD;
                        cnt              <= 3'd0;
                        ap_idle          <= 1'b0;
                        statemt_ce0      <= 1'b1;
                        statemt_ce1      <= 1'b1;
                        statemt_address0 <= 5'd0;
                        statemt_address1 <= 5'd1;
                    end
                end
                S_RD: begin
                    if (cnt == 3'd7) begin
                        state <= S_RDW;
                    end else begin
                        cnt              <= cnt_inc;
                        statemt_ce0      <= 1'b1;
                        statemt_ce1      <= 1'b1;
                        statemt_address0 <= {1'b0, cnt_inc, 1'b0};
                        statemt_address1 <= {1'b0, cnt_inc, 1'b1};
                    end
                end
                S_RDW: begin
                    // Pair 0 needs input bytes 0 and 13, both already
                    // buffered; bytes 14/15 land in the buffer this edge.
                    state            <= S_LK;
                    cnt              <= 3'd0;
                    invsbox_ce0      <= 1'b1;
                    invsbox_ce1      <= 1'b1;
                    invsbox_address0 <= byte_buf[src_idx(4'd0)];
                    invsbox_address1 <= byte_buf[src_idx(4'd1)];
                end
                S_LK: begin
                    // ROM data for pair m is back next cycle: write it then.
                    statemt_ce0      <= 1'b1;
                    statemt_ce1      <= 1'b1;
                    statemt_we0      <= 1'b1;
                    statemt_we1      <= 1'b1;
                    statemt_address0 <= {1'b0, cnt, 1'b0};
                    statemt_address1 <= {1'b0, cnt, 1'b1};
                    if (cnt == 3'd7) begin
                        state <= S_WR;
                    end else begin
                        cnt              <= cnt_inc;
                        invsbox_ce0      <= 1'b1;
                        invsbox_ce1      <= 1'b1;
                        invsbox_address0 <= byte_buf[src_idx({cnt_inc, 1'b0})];
                        invsbox_address1 <= byte_buf[src_idx({cnt_inc, 1'b1})];
                    end
                end
                S_WR: begin
                    state    <= S_DONE;
                    ap_done  <= 1'b1;
                    ap_ready <= 1'b1;
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    ap_idle <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    ap_idle <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inverse_shift_row_byte_sub.sv
// ---------------------------------------------------------------------------
// tb_inverse_shift_row_byte_sub
//
// Bench for inverse_shift_row_byte_sub. It models the statemt memory and the
// inverse S-box ROM, drives runs with directed and random contents, and
// checks every cycle's control/memory outputs against a cycle-position model
// plus the final memory contents against the AES InvShiftRows/InvSubBytes
// rule. The inverse S-box is generated from the GF(2^8) definition of AES.
// ---------------------------------------------------------------------------
module tb_inverse_shift_row_byte_sub;

    logic        ap_clk;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [4:0]  statemt_address0;
    logic        statemt_ce0;
    logic        statemt_we0;
    logic [31:0] statemt_d0;
    logic [31:0] statemt_q0;
    logic [4:0]  statemt_address1;
    logic        statemt_ce1;
    logic        statemt_we1;
    logic [31:0] statemt_d1;
    logic [31:0] statemt_q1;
    logic [7:0]  invsbox_address0;
    logic        invsbox_ce0;
    logic [7:0]  invsbox_q0;
    logic [7:0]  invsbox_address1;
    logic        invsbox_ce1;
    logic [7:0]  invsbox_q1;

    inverse_shift_row_byte_sub dut (
        .ap_clk           (ap_clk),
        .ap_rst           (ap_rst),
        .ap_start         (ap_start),
        .ap_done          (ap_done),
        .ap_idle          (ap_idle),
        .ap_ready         (ap_ready),
        .statemt_address0 (statemt_address0),
        .statemt_ce0      (statemt_ce0),
        .statemt_we0      (statemt_we0),
        .statemt_d0       (statemt_d0),
        .statemt_q0       (statemt_q0),
        .statemt_address1 (statemt_address1),
        .statemt_ce1      (statemt_ce1),
        .statemt_we1      (statemt_we1),
        .statemt_d1       (statemt_d1),
        .statemt_q1       (statemt_q1),
        .invsbox_address0 (invsbox_address0),
        .invsbox_ce0      (invsbox_ce0),
        .invsbox_q0       (invsbox_q0),
        .invsbox_address1 (invsbox_address1),
        .invsbox_ce1      (invsbox_ce1),
        .invsbox_q1       (invsbox_q1)
    );

    // ---------------- clock ----------------
    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    // ---------------- memory and ROM models ----------------
    logic [31:0] mem      [32];
    logic [31:0] init_mem [32];
    logic [7:0]  rom      [256];
    logic [7:0]  inv_sbox [256];
    logic        load_req;

    always @(posedge ap_clk) begin
        if (load_req) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_mem[i];
        end else begin
            if (statemt_ce0) begin
                if (statemt_we0) mem[statemt_address0] <= statemt_d0;
                statemt_q0 <= mem[statemt_address0];
            end
            if (statemt_ce1) begin
                if (statemt_we1) mem[statemt_address1] <= statemt_d1;
                statemt_q1 <= mem[statemt_address1];
            end
        end
        if (invsbox_ce0) invsbox_q0 <= rom[invsbox_address0];
        if (invsbox_ce1) invsbox_q1 <= rom[invsbox_address1];
    end

    // ---------------- scoreboard state ----------------
    int          total;
    int          bad;
    int          cyc;
    logic        chk_en;
    logic        busy;
    int          offs;
    logic        done_seen;
    int          done_cyc;
    logic [36:0] exp_q [$];   // {address, data} per expected port write

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at cycle %0d: actual=0x%0h required=0x%0h", name, cyc, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'd0;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_inv_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'd0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'd1) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            inv_sbox[s] = 8'(x);
        end
    endtask

    // out[r + 4c] takes the byte from column (c - r) mod 4 of the same row.
    function automatic int src_of(input int i);
        int r;
        int c;
        r = i % 4;
        c = i / 4;
        return r + 4 * ((c - r + 4) % 4);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] w [32], input int i);
        logic [31:0] v;
        v = w[src_of(i)];
        return {24'b0, rom[v[7:0]]};
    endfunction

    // ---------------- per-cycle check + clock step ----------------
    task automatic cycle_checks();
        logic exp_rd;
        logic exp_wr;
        logic exp_lk;
        logic [36:0] e0;
        logic [36:0] e1;
        exp_rd = busy && offs >= 1 && offs <= 8;
        exp_wr = busy && offs >= 11 && offs <= 18;
        exp_lk = busy && offs >= 10 && offs <= 17;
        chk("ap_idle", ap_idle, !busy);
        chk("ap_done", ap_done, busy && offs == 19);
        chk("ap_ready", ap_ready, busy && offs == 19);
        chk("statemt_en", {statemt_ce0, statemt_ce1, statemt_we0, statemt_we1},
            {exp_rd | exp_wr, exp_rd | exp_wr, exp_wr, exp_wr});
        chk("invsbox_ce", {invsbox_ce0, invsbox_ce1}, {exp_lk, exp_lk});
        if (exp_rd)
            chk("rd_addr", {statemt_address0, statemt_address1},
                {5'(2 * (offs - 1)), 5'(2 * (offs - 1) + 1)});
        if (exp_wr) begin
            if (exp_q.size() >= 2) begin
                e0 = exp_q.pop_front();
                e1 = exp_q.pop_front();
                chk("wr_port0", {statemt_address0, statemt_d0}, e0);
                chk("wr_port1", {statemt_address1, statemt_d1}, e1);
            end else begin
                chk("wr_queue", exp_q.size(), 2);
            end
        end
    endtask

    task automatic step();
        logic [31:0] snap [32];
        @(negedge ap_clk);
        if (chk_en) cycle_checks();
        if (ap_done === 1'b1) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
        if (ap_rst) begin
            busy = 1'b0;
            offs = 0;
            exp_q.delete();
        end else if (busy) begin
            if (offs == 19) begin
                busy = 1'b0;
                offs = 0;
            end else begin
                offs++;
            end
        end else if (ap_start) begin
            busy = 1'b1;
            offs = 1;
            snap = mem;
            exp_q.delete();
            for (int i = 0; i < 16; i++) exp_q.push_back({5'(i), ref_word(snap, i)});
        end
        @(posedge ap_clk);
        cyc++;
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_mem();
        load_req = 1'b1;
        step();
        load_req = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int t);
        done_seen = 1'b0;
        for (int n = 0; n < limit && !done_seen; n++) step();
        chk("done_timeout", done_seen, 1'b1);
        t = done_seen ? done_cyc : -1000;
    endtask

    task automatic check_tail();
        for (int i = 16; i < 32; i++) chk("untouched_word", mem[i], init_mem[i]);
    endtask

    task automatic run_job(input string name);
        int t_acc;
        int t_done;
        load_mem();
        ap_start = 1'b1;
        t_acc = cyc;
        step();
        ap_start = 1'b0;
        wait_done(40, t_done);
        chk({name, "_latency"}, 64'(t_done - t_acc), 64'd19);
        step();
        for (int i = 0; i < 16; i++) chk({name, "_word"}, mem[i], ref_word(init_mem, i));
        check_tail();
    endtask

    task automatic fill_rom(input int mode);
        for (int a = 0; a < 256; a++) begin
            case (mode)
                0:       rom[a] = 8'(a);
                1:       rom[a] = inv_sbox[a];
                default: rom[a] = 8'($urandom_range(0, 255));
            endcase
        end
    endtask

    task automatic fill_tail();
        for (int i = 16; i < 32; i++) init_mem[i] = $urandom;
    endtask

    // ---------------- main sequence ----------------
    int exp_id [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

    initial begin
        logic [31:0] r1 [32];
        int t1;
        int t2;
        total = 0; bad = 0; cyc = 0;
        chk_en = 1'b0; busy = 1'b0; offs = 0; done_seen = 1'b0; done_cyc = 0;
        ap_rst = 1'b1; ap_start = 1'b0; load_req = 1'b0;
        build_inv_sbox();
        for (int i = 0; i < 32; i++) init_mem[i] = 32'd0;

        repeat (3) step();
        chk("rst_idle", ap_idle, 1'b1);
        chk("rst_done_ready", {ap_done, ap_ready}, 2'b00);
        chk("rst_enables", {statemt_ce0, statemt_ce1, statemt_we0, statemt_we1,
                            invsbox_ce0, invsbox_ce1}, 6'd0);
        chk("rst_addr", {statemt_address0, statemt_address1,
                         invsbox_address0, invsbox_address1}, 26'd0);
        chk("rst_data", {statemt_d0, statemt_d1}, 64'd0);
        ap_rst = 1'b0;
        chk_en = 1'b1;
        step();

        // pin the generated inverse S-box to known table entries
        chk("inv_sbox_63", inv_sbox[8'h63], 8'h00);
        chk("inv_sbox_00", inv_sbox[8'h00], 8'h52);
        chk("inv_sbox_01", inv_sbox[8'h01], 8'h09);

        // identity ROM, in[i] = i
        fill_rom(0);
        fill_tail();
        for (int i = 0; i < 16; i++) init_mem[i] = 32'(i);
        run_job("ident");
        for (int i = 0; i < 16; i++) chk("ident_literal", mem[i], 32'(exp_id[i]));

        // real inverse S-box, constant inputs
        fill_rom(1);
        for (int i = 0; i < 16; i++) init_mem[i] = 32'h63;
        run_job("sbox63");
        for (int i = 0; i < 16; i++) chk("sbox63_literal", mem[i], 32'h0);
        for (int i = 0; i < 16; i++) init_mem[i] = 32'h0;
        run_job("sbox00");
        for (int i = 0; i < 16; i++) chk("sbox00_literal", mem[i], 32'h52);

        // upper bits ignored
        fill_rom(0);
        for (int i = 0; i < 16; i++) init_mem[i] = 32'hFFFFFF00 | 32'(i);
        run_job("upper");
        for (int i = 0; i < 16; i++) chk("upper_literal", mem[i], 32'(exp_id[i]));

        // randomized runs
        for (int j = 0; j < 8; j++) begin
            fill_rom($urandom_range(0, 2));
            fill_tail();
            for (int i = 0; i < 16; i++) init_mem[i] = $urandom;
            repeat ($urandom_range(0, 4)) step();
            run_job("rand");
        end

        // reset in the third LK cycle (T+12)
        fill_rom(2);
        fill_tail();
        for (int i = 0; i < 16; i++) init_mem[i] = $urandom;
        load_mem();
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        repeat (11) step();
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
        chk("midrst_idle", ap_idle, 1'b1);
        chk("midrst_enables", {statemt_ce0, statemt_ce1, statemt_we0, statemt_we1,
                               invsbox_ce0, invsbox_ce1}, 6'd0);
        repeat (4) step();
        for (int i = 0; i < 4; i++) chk("midrst_new_word", mem[i], ref_word(init_mem, i));
        for (int i = 4; i < 16; i++) chk("midrst_orig_word", mem[i], init_mem[i]);
        check_tail();

        // back-to-back with ap_start held high
        fill_rom(0);
        fill_tail();
        for (int i = 0; i < 16; i++) init_mem[i] = 32'(i);
        load_mem();
        ap_start = 1'b1;
        step();
        wait_done(40, t1);
        step();
        ap_start = 1'b0;
        wait_done(40, t2);
        chk("b2b_period", 64'(t2 - t1), 64'd20);
        step();
        r1 = init_mem;
        for (int i = 0; i < 16; i++) r1[i] = ref_word(init_mem, i);
        for (int i = 0; i < 16; i++) chk("b2b_word", mem[i], ref_word(r1, i));
        chk("b2b_word1_literal", mem[1], 32'd9);
        check_tail();

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
